// File: rtl/cave_input_pkg.sv
// Shared constants for the Cave input conditioning stage: scan codes, joystick
// and output bit positions, and the per-player conditioning helpers.
package cave_input_pkg;

  localparam int COIN_CNT_W = 24;

  // Player 1 scan codes
  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] KEY_B1    = 8'h14;
  localparam logic [7:0] KEY_B2    = 8'h11;
  localparam logic [7:0] KEY_B3    = 8'h29;
  localparam logic [7:0] KEY_START = 8'h16;
  localparam logic [7:0] KEY_COIN  = 8'h2E;
  localparam logic [7:0] KEY_PAUSE = 8'h4D;

  // Player 2 scan codes (no pause key)
  localparam logic [7:0] KEY_P2_UP    = 8'h2D;
  localparam logic [7:0] KEY_P2_DOWN  = 8'h2B;
  localparam logic [7:0] KEY_P2_LEFT  = 8'h23;
  localparam logic [7:0] KEY_P2_RIGHT = 8'h34;
  localparam logic [7:0] KEY_P2_B1    = 8'h1C;
  localparam logic [7:0] KEY_P2_B2    = 8'h1B;
  localparam logic [7:0] KEY_P2_B3    = 8'h15;
  localparam logic [7:0] KEY_P2_START = 8'h1E;
  localparam logic [7:0] KEY_P2_COIN  = 8'h36;

  localparam logic [7:0] KEY_SERVICE1 = 8'h46;
  localparam logic [7:0] KEY_SERVICE2 = 8'h45;

  localparam int BIT_RIGHT = 0;
  localparam int BIT_LEFT  = 1;
  localparam int BIT_DOWN  = 2;
  localparam int BIT_UP    = 3;
  localparam int BIT_B1    = 4;
  localparam int BIT_B2    = 5;
  localparam int BIT_B3    = 6;
  localparam int BIT_START = 7;
  localparam int BIT_COIN  = 8;
  localparam int BIT_PAUSE = 9;

  localparam int JOY_RIGHT   = 0;
  localparam int JOY_LEFT    = 1;
  localparam int JOY_DOWN    = 2;
  localparam int JOY_UP      = 3;
  localparam int JOY_B1      = 4;
  localparam int JOY_B2      = 5;
  localparam int JOY_B3      = 6;
  localparam int JOY_START   = 7;
  localparam int JOY_COIN    = 8;
  localparam int JOY_PAUSE   = 9;
  localparam int JOY_SERVICE = 10;

  // Field order matches the Main player word: bit 9 = pause ... bit 0 = right.
  typedef struct packed {
    logic pause;
    logic coin;
    logic start;
    logic b3;
    logic b2;
    logic b1;
    logic up;
    logic down;
    logic left;
    logic right;
  } player_t;

  function automatic player_t joy_to_player(input logic [10:0] joy);
    player_t p;
    p.right = joy[JOY_RIGHT];
    p.left  = joy[JOY_LEFT];
    p.down  = joy[JOY_DOWN];
    p.up    = joy[JOY_UP];
    p.b1    = joy[JOY_B1];
    p.b2    = joy[JOY_B2];
    p.b3    = joy[JOY_B3];
    p.start = joy[JOY_START];
    p.coin  = joy[JOY_COIN];
    p.pause = joy[JOY_PAUSE];
    return p;
  endfunction

  // Opposing directions cancel; the coin level is replaced by the shaped pulse.
  function automatic player_t condition(input player_t raw, input logic coin_pulse);
    player_t p;
    p = raw;
    if (raw.up && raw.down) begin
      p.up   = 1'b0;
      p.down = 1'b0;
    end
    if (raw.left && raw.right) begin
      p.left  = 1'b0;
      p.right = 1'b0;
    end
    p.coin = coin_pulse;
    return p;
  endfunction

endpackage

// File: rtl/cave_coin_pulse.sv
// Turns a rising edge of a coin level into a fixed-length pulse; edges that
// arrive while a pulse is running are dropped.
module cave_coin_pulse
  import cave_input_pkg::*;
#(
  parameter int unsigned WIDTH = 4_800_000
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);

  localparam logic [COIN_CNT_W-1:0] LOAD = COIN_CNT_W'(WIDTH);

  logic                  in_q;
  logic [COIN_CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_q <= 1'b0;
      cnt  <= '0;
    end else begin
      in_q <= in;
      if (cnt != '0)
        cnt <= cnt - COIN_CNT_W'(1);
      else if (in && !in_q)
        cnt <= LOAD;
    end
  end

  assign out = (cnt != '0);

endmodule

// File: rtl/cave_input_ctrl.sv
// Input conditioning for the Cave Main core: PS/2 key states merged with
// MiSTer joystick bits, opposing-direction cancel and shaped coin pulses.
module cave_input_ctrl
  import cave_input_pkg::*;
#(
  parameter int unsigned COIN_WIDTH = 4_800_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] ps2_key,
  input  logic [31:0] joystick_0,
  input  logic [31:0] joystick_1,
  output logic [9:0]  player1,
  output logic [9:0]  player2,
  output logic [1:0]  service
);

  logic    toggle_q;
  logic    key_event;
  player_t key_p1;
  player_t key_p2;
  logic [1:0] key_svc;

  player_t raw_p1;
  player_t raw_p2;
  logic [1:0] raw_svc;
  logic    coin_p1;
  logic    coin_p2;

  logic unused_bits;
  assign unused_bits = ^{ps2_key[8], joystick_0[31:11], joystick_1[31:11]};

  assign key_event = ps2_key[10] ^ toggle_q;

  // toggle_q follows ps2_key even in reset so release never looks like an event.
  always_ff @(posedge clk) begin
    if (rst) begin
      toggle_q <= ps2_key[10];
      key_p1   <= '0;
      key_p2   <= '0;
      key_svc  <= '0;
    end else begin
      toggle_q <= ps2_key[10];
      if (key_event) begin
        case (ps2_key[7:0])
          KEY_UP:       key_p1.up    <= ps2_key[9];
          KEY_DOWN:     key_p1.down  <= ps2_key[9];
          KEY_LEFT:     key_p1.left  <= ps2_key[9];
          KEY_RIGHT:    key_p1.right <= ps2_key[9];
          KEY_B1:       key_p1.b1    <= ps2_key[9];
          KEY_B2:       key_p1.b2    <= ps2_key[9];
          KEY_B3:       key_p1.b3    <= ps2_key[9];
          KEY_START:    key_p1.start <= ps2_key[9];
          KEY_COIN:     key_p1.coin  <= ps2_key[9];
          KEY_PAUSE:    key_p1.pause <= ps2_key[9];
          KEY_P2_UP:    key_p2.up    <= ps2_key[9];
          KEY_P2_DOWN:  key_p2.down  <= ps2_key[9];
          KEY_P2_LEFT:  key_p2.left  <= ps2_key[9];
          KEY_P2_RIGHT: key_p2.right <= ps2_key[9];
          KEY_P2_B1:    key_p2.b1    <= ps2_key[9];
          KEY_P2_B2:    key_p2.b2    <= ps2_key[9];
          KEY_P2_B3:    key_p2.b3    <= ps2_key[9];
          KEY_P2_START: key_p2.start <= ps2_key[9];
          KEY_P2_COIN:  key_p2.coin  <= ps2_key[9];
          KEY_SERVICE1: key_svc[0]   <= ps2_key[9];
          KEY_SERVICE2: key_svc[1]   <= ps2_key[9];
          default: ;
        endcase
      end
    end
  end

  assign raw_p1  = key_p1 | joy_to_player(joystick_0[10:0]);
  assign raw_p2  = key_p2 | joy_to_player(joystick_1[10:0]);
  assign raw_svc = key_svc | {joystick_1[JOY_SERVICE], joystick_0[JOY_SERVICE]};

  cave_coin_pulse #(.WIDTH(COIN_WIDTH)) u_coin_p1 (
    .clk (clk),
    .rst (rst),
    .in  (raw_p1.coin),
    .out (coin_p1)
  );

  cave_coin_pulse #(.WIDTH(COIN_WIDTH)) u_coin_p2 (
    .clk (clk),
    .rst (rst),
    .in  (raw_p2.coin),
    .out (coin_p2)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      player1 <= '0;
      player2 <= '0;
      service <= '0;
    end else begin
      player1 <= condition(raw_p1, coin_p1);
      player2 <= condition(raw_p2, coin_p2);
      service <= raw_svc;
    end
  end

endmodule

// File: tb/tb_cave_input_ctrl.sv
// Directed bench for cave_input_ctrl with a short coin pulse; expected output
// words are queued per cycle and checked by an independent monitor.
module tb_cave_input_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] ps2_key;
  logic [31:0] joystick_0;
  logic [31:0] joystick_1;
  logic [9:0]  player1;
  logic [9:0]  player2;
  logic [1:0]  service;

  cave_input_ctrl #(.COIN_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_key    (ps2_key),
    .joystick_0 (joystick_0),
    .joystick_1 (joystick_1),
    .player1    (player1),
    .player2    (player2),
    .service    (service)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [21:0] val;
    int          tag;
  } exp_t;

  exp_t  q[$];
  string qn[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    step_no = 0;
  string phase = "init";
  exp_t  e_cur;
  string n_cur;

  localparam logic [21:0] Z = 22'd0;

  function automatic logic [21:0] o(input logic [1:0] s, input logic [9:0] p2, input logic [9:0] p1);
    return {s, p2, p1};
  endfunction

  // Queue the output word expected after the coming rising edge, then move
  // on to the following falling edge where the next inputs are driven.
  task automatic step(input logic [21:0] e);
    exp_t x;
    x.val = e;
    x.tag = step_no;
    step_no++;
    q.push_back(x);
    qn.push_back(phase);
    @(negedge clk);
  endtask

  task automatic kev(input logic [7:0] code, input logic pressed);
    ps2_key = {~ps2_key[10], pressed, 1'b0, code};
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      e_cur = q.pop_front();
      n_cur = qn.pop_front();
      n_cmp++;
      if ({service, player2, player1} !== e_cur.val) begin
        n_bad++;
        $display("FAIL %s step%0d got svc=%b p2=%b p1=%b want svc=%b p2=%b p1=%b",
                 n_cur, e_cur.tag, service, player2, player1,
                 e_cur.val[21:20], e_cur.val[19:10], e_cur.val[9:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: stimulus did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    ps2_key = 11'h400;
    joystick_0 = 32'hFFFF_FFFF;
    joystick_1 = 32'hFFFF_FFFF;
    @(negedge clk);

    phase = "reset";
    repeat (3) step(Z);
    rst = 1'b0;
    phase = "reset_release";
    step(o(2'b11, 10'h2F0, 10'h2F0));
    phase = "coin_after_reset";
    repeat (8) step(o(2'b11, 10'h3F0, 10'h3F0));
    repeat (2) step(o(2'b11, 10'h2F0, 10'h2F0));
    joystick_0 = '0;
    joystick_1 = '0;
    step(Z);

    phase = "key_press";
    kev(8'h75, 1'b1); step(Z);
    step(o(2'b00, 10'h000, 10'h008));
    phase = "key_release";
    kev(8'h75, 1'b0); step(o(2'b00, 10'h000, 10'h008));
    phase = "no_toggle";
    ps2_key[9] = 1'b1; step(Z);
    step(Z);
    step(Z);

    phase = "one_cycle_key";
    kev(8'h75, 1'b1); step(Z);
    kev(8'h75, 1'b0); step(o(2'b00, 10'h000, 10'h008));
    step(Z);

    phase = "unmapped";
    kev(8'h5A, 1'b1); step(Z);
    step(Z);

    phase = "service_merge";
    kev(8'h46, 1'b1); step(Z);
    step(o(2'b01, 10'h000, 10'h000));
    kev(8'h45, 1'b1); joystick_0 = 32'h10; step(o(2'b01, 10'h000, 10'h010));
    step(o(2'b11, 10'h000, 10'h010));
    kev(8'h46, 1'b0); joystick_0 = '0; step(o(2'b11, 10'h000, 10'h000));
    kev(8'h45, 1'b0); step(o(2'b10, 10'h000, 10'h000));
    step(Z);

    phase = "coin_joy";
    joystick_0 = 32'h100; step(Z);
    repeat (8) step(o(2'b00, 10'h000, 10'h100));
    repeat (11) step(Z);
    joystick_0 = '0;
    repeat (3) step(Z);
    phase = "coin_joy_second";
    joystick_0 = 32'h100; step(Z);
    step(o(2'b00, 10'h000, 10'h100));
    joystick_0 = '0;
    repeat (7) step(o(2'b00, 10'h000, 10'h100));
    repeat (2) step(Z);

    phase = "no_retrigger";
    kev(8'h2E, 1'b1); step(Z);
    step(Z);
    kev(8'h2E, 1'b0); step(o(2'b00, 10'h000, 10'h100));
    kev(8'h2E, 1'b1); step(o(2'b00, 10'h000, 10'h100));
    kev(8'h2E, 1'b0); step(o(2'b00, 10'h000, 10'h100));
    repeat (5) step(o(2'b00, 10'h000, 10'h100));
    repeat (2) step(Z);

    phase = "socd";
    joystick_1 = 32'h0C; kev(8'h23, 1'b1); step(Z);
    step(o(2'b00, 10'h002, 10'h000));
    joystick_1 = 32'h08; step(o(2'b00, 10'h00A, 10'h000));
    joystick_1 = 32'h09; step(o(2'b00, 10'h008, 10'h000));
    joystick_1 = '0; kev(8'h23, 1'b0); step(o(2'b00, 10'h002, 10'h000));
    step(Z);

    phase = "reset_mid_pulse";
    kev(8'h2E, 1'b1); step(Z);
    step(Z);
    repeat (4) step(o(2'b00, 10'h000, 10'h100));
    rst = 1'b1;
    step(Z);
    step(Z);
    rst = 1'b0;
    phase = "after_reset_no_pulse";
    repeat (4) step(Z);
    kev(8'h2E, 1'b0); step(Z);
    step(Z);
    phase = "after_reset_new_rise";
    kev(8'h2E, 1'b1); step(Z);
    step(Z);
    repeat (8) step(o(2'b00, 10'h000, 10'h100));
    step(Z);

    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected words left unchecked, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
